// File: rtl/cmd_regfile_pkg.sv
// cmd_regfile_pkg
// Shared definitions for the byte-serial command register file:
//   state_t       - protocol FSM states
//   CMD_WR/CMD_RD - command byte encodings
//   ERR_CNT_MAX   - saturation value of the error counter
package cmd_regfile_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WDATA,
        TX_LOAD,
        TX_WAIT
    } state_t;

    localparam logic [7:0] CMD_WR      = 8'h01;
    localparam logic [7:0] CMD_RD      = 8'h02;
    localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

endpackage

// File: rtl/byte_timeout.sv
// byte_timeout
// Counts consecutive idle cycles while a frame is being received and flags
// when TIMEOUT_CYC of them have elapsed.
// Ports:
//   clk     - clock, rising edge
//   rst_n   - asynchronous reset, active-high
//   run     - counting enabled (frame in progress)
//   clr     - restart the count (a byte arrived)
//   expired - high during the TIMEOUT_CYC-th consecutive idle cycle
module byte_timeout #(
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clr,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // The count holds at LAST so expiry stays asserted until the FSM reacts.
    always_comb begin
        cnt_d = cnt_q;
        if (!run || clr) begin
            cnt_d = '0;
        end else if (cnt_q != LAST) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = run && (cnt_q == LAST);

endmodule

// File: rtl/cmd_regfile.sv
// cmd_regfile
// Register file accessed by a byte protocol: CMD, ADDR, then for writes
// DATA_W/8 data bytes MSB first. Reads answer with DATA_W/8 bytes over a
// tx_wr/tx_done handshake.
// Ports:
//   clk, rst_n       - clock (rising edge), async active-high reset
//   rx_done, data_i  - received byte strobe and byte
//   tx_done          - transmitter finished the current byte
//   tx_wr, tx_data   - byte-to-send strobe and byte (held until tx_done)
//   regs_o           - flattened registers, reg k at [k*DATA_W +: DATA_W]
//   err, err_cnt     - protocol error strobe and saturating error count
module cmd_regfile
    import cmd_regfile_pkg::*;
#(
    parameter int NUM_REGS    = 4,
    parameter int DATA_W      = 16,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       rx_done,
    input  logic [7:0]                 data_i,
    input  logic                       tx_done,
    output logic                       tx_wr,
    output logic [7:0]                 tx_data,
    output logic [NUM_REGS*DATA_W-1:0] regs_o,
    output logic                       err,
    output logic [7:0]                 err_cnt
);

    localparam int NB = DATA_W / 8;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;
    localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [CW-1:0] LAST_BYTE  = CW'(NB - 1);
    localparam logic [8:0]    NUM_REGS_9 = 9'(NUM_REGS);

    state_t              state_q, state_d;
    logic                is_rd_q, is_rd_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic                addr_ok_q, addr_ok_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0]   asm_q, asm_d;
    logic [DATA_W-1:0]   rd_q, rd_d;
    logic                err_q, err_d;
    logic [7:0]          err_cnt_q, err_cnt_d;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];

    logic                reg_we;
    logic                expired;
    logic                addr_in_range;
    logic [DATA_W-1:0]   asm_next;

    assign addr_in_range = ({1'b0, data_i} < NUM_REGS_9);
    assign asm_next      = (asm_q << 8) | DATA_W'(data_i);

    // Only ADDR and WDATA wait on the sender; every received byte restarts it.
    byte_timeout #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .run    ((state_q == ADDR) || (state_q == WDATA)),
        .clr    (rx_done),
        .expired(expired)
    );

    // A received byte is checked before expiry so a byte arriving on the
    // expiry cycle is accepted. The read value is captured into rd_q at the
    // address byte and shifted out MSB first, so the reply never tears.
    always_comb begin
        state_d   = state_q;
        is_rd_d   = is_rd_q;
        addr_d    = addr_q;
        addr_ok_d = addr_ok_q;
        cnt_d     = cnt_q;
        asm_d     = asm_q;
        rd_d      = rd_q;
        err_d     = 1'b0;
        reg_we    = 1'b0;
        case (state_q)
            IDLE: begin
                if (rx_done) begin
                    if ((data_i == CMD_WR) || (data_i == CMD_RD)) begin
                        state_d = ADDR;
                        is_rd_d = (data_i == CMD_RD);
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ADDR: begin
                if (rx_done) begin
                    addr_d    = data_i[AW-1:0];
                    addr_ok_d = addr_in_range;
                    err_d     = !addr_in_range;
                    cnt_d     = '0;
                    if (is_rd_q) begin
                        rd_d    = addr_in_range ? regs_q[data_i[AW-1:0]] : '0;
                        state_d = TX_LOAD;
                    end else begin
                        asm_d   = '0;
                        state_d = WDATA;
                    end
                end else if (expired) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
            WDATA: begin
                if (rx_done) begin
                    asm_d = asm_next;
                    if (cnt_q == LAST_BYTE) begin
                        state_d = IDLE;
                        reg_we  = addr_ok_q;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else if (expired) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
            TX_LOAD: begin
                state_d = TX_WAIT;
                err_d   = rx_done;
            end
            TX_WAIT: begin
                err_d = rx_done;
                if (tx_done) begin
                    if (cnt_q == LAST_BYTE) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d   = cnt_q + CW'(1);
                        rd_d    = rd_q << 8;
                        state_d = TX_LOAD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Registers change only on the final byte of a complete, in-range write.
    always_comb begin
        regs_d = regs_q;
        if (reg_we) begin
            regs_d[addr_q] = asm_next;
        end
    end

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_d && (err_cnt_q != ERR_CNT_MAX)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q   <= IDLE;
            is_rd_q   <= 1'b0;
            addr_q    <= '0;
            addr_ok_q <= 1'b0;
            cnt_q     <= '0;
            asm_q     <= '0;
            rd_q      <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            is_rd_q   <= is_rd_d;
            addr_q    <= addr_d;
            addr_ok_q <= addr_ok_d;
            cnt_q     <= cnt_d;
            asm_q     <= asm_d;
            rd_q      <= rd_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
            regs_q    <= regs_d;
        end
    end

    assign tx_wr   = (state_q == TX_LOAD);
    assign tx_data = rd_q[DATA_W-1 -: 8];
    assign err     = err_q;
    assign err_cnt = err_cnt_q;

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs_o
        assign regs_o[k*DATA_W +: DATA_W] = regs_q[k];
    end

endmodule

// File: tb/tb_cmd_regfile.sv
// tb_cmd_regfile
// Directed bench for cmd_regfile (NUM_REGS=4, DATA_W=16, TIMEOUT_CYC=1000).
// A table of write/read frames with hand-computed register images and reply
// bytes, followed by hand-written sequences for timeout, overrun, reset and
// error-count saturation.
module tb_cmd_regfile;

    localparam int NUM_REGS    = 4;
    localparam int DATA_W      = 16;
    localparam int TIMEOUT_CYC = 1000;

    logic        clk;
    logic        rst_n;
    logic        rx_done;
    logic [7:0]  data_i;
    logic        tx_done;
    logic        tx_wr;
    logic [7:0]  tx_data;
    logic [63:0] regs_o;
    logic        err;
    logic [7:0]  err_cnt;

    int checks;
    int failures;
    int expErrCnt;

    typedef struct {
        logic        isRead;
        logic [7:0]  addr;
        logic [15:0] data;
        logic        expErr;
        logic [63:0] expRegs;
    } vec_t;

    vec_t vecs [8];

    cmd_regfile #(
        .NUM_REGS   (NUM_REGS),
        .DATA_W     (DATA_W),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .rx_done(rx_done),
        .data_i (data_i),
        .tx_done(tx_done),
        .tx_wr  (tx_wr),
        .tx_data(tx_data),
        .regs_o (regs_o),
        .err    (err),
        .err_cnt(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic bumpErr();
        if (expErrCnt < 255) expErrCnt++;
    endtask

    // Called at a negedge; returns at the next negedge with the byte consumed.
    task automatic pulseRx(input logic [7:0] b);
        rx_done = 1'b1;
        data_i  = b;
        @(negedge clk);
        rx_done = 1'b0;
        data_i  = 8'h00;
    endtask

    task automatic pulseTx();
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        pulseRx(v.isRead ? 8'h02 : 8'h01);
        pulseRx(v.addr);
        checkOutput("addr_err", 64'(err), 64'(v.expErr));
        if (v.expErr) bumpErr();
        if (!v.isRead) begin
            pulseRx(v.data[15:8]);
            pulseRx(v.data[7:0]);
        end else begin
            checkOutput("rd_txwr0", 64'(tx_wr), 64'd1);
            checkOutput("rd_msb", 64'(tx_data), 64'(v.data[15:8]));
            @(negedge clk);
            checkOutput("rd_wait", 64'(tx_wr), 64'd0);
            pulseTx();
            checkOutput("rd_txwr1", 64'(tx_wr), 64'd1);
            checkOutput("rd_lsb", 64'(tx_data), 64'(v.data[7:0]));
            @(negedge clk);
            pulseTx();
            checkOutput("rd_done", 64'(tx_wr), 64'd0);
        end
        checkOutput("regs", regs_o, v.expRegs);
        checkOutput("err_cnt", 64'(err_cnt), 64'(expErrCnt));
    endtask

    initial begin
        int txSeen;
        checks    = 0;
        failures  = 0;
        expErrCnt = 0;
        rst_n     = 1'b1;
        rx_done   = 1'b0;
        data_i    = 8'h00;
        tx_done   = 1'b0;

        vecs[0] = '{1'b0, 8'h02, 16'hABCD, 1'b0, 64'h0000_ABCD_0000_0000};
        vecs[1] = '{1'b1, 8'h02, 16'hABCD, 1'b0, 64'h0000_ABCD_0000_0000};
        vecs[2] = '{1'b0, 8'h00, 16'h1234, 1'b0, 64'h0000_ABCD_0000_1234};
        vecs[3] = '{1'b0, 8'h03, 16'hFFFF, 1'b0, 64'hFFFF_ABCD_0000_1234};
        vecs[4] = '{1'b1, 8'h09, 16'h0000, 1'b1, 64'hFFFF_ABCD_0000_1234};
        vecs[5] = '{1'b0, 8'h80, 16'h5555, 1'b1, 64'hFFFF_ABCD_0000_1234};
        vecs[6] = '{1'b1, 8'h03, 16'hFFFF, 1'b0, 64'hFFFF_ABCD_0000_1234};
        vecs[7] = '{1'b1, 8'h00, 16'h1234, 1'b0, 64'hFFFF_ABCD_0000_1234};

        repeat (3) @(negedge clk);
        checkOutput("rst_regs", regs_o, 64'h0);
        checkOutput("rst_txwr", 64'(tx_wr), 64'd0);
        checkOutput("rst_txdata", 64'(tx_data), 64'h00);
        checkOutput("rst_err", 64'(err), 64'd0);
        checkOutput("rst_errcnt", 64'(err_cnt), 64'd0);
        rst_n = 1'b0;
        @(negedge clk);

        // Bad command byte in IDLE
        pulseRx(8'h07);
        bumpErr();
        checkOutput("badcmd_err", 64'(err), 64'd1);
        checkOutput("badcmd_cnt", 64'(err_cnt), 64'(expErrCnt));
        @(negedge clk);
        checkOutput("badcmd_pulse", 64'(err), 64'd0);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i]);
        end

        // Timeout after a partial write leaves reg1 untouched
        pulseRx(8'h01);
        pulseRx(8'h01);
        pulseRx(8'h12);
        repeat (TIMEOUT_CYC - 1) @(negedge clk);
        checkOutput("tmo_early", 64'(err), 64'd0);
        @(negedge clk);
        checkOutput("tmo_err", 64'(err), 64'd1);
        bumpErr();
        checkOutput("tmo_regs", regs_o, 64'hFFFF_ABCD_0000_1234);
        checkOutput("tmo_cnt", 64'(err_cnt), 64'(expErrCnt));

        // Byte arriving on the expiry cycle is accepted
        pulseRx(8'h01);
        pulseRx(8'h01);
        repeat (TIMEOUT_CYC - 1) @(negedge clk);
        pulseRx(8'h34);
        checkOutput("tmo_race_err", 64'(err), 64'd0);
        pulseRx(8'h56);
        checkOutput("tmo_race_regs", regs_o, 64'hFFFF_ABCD_3456_1234);
        checkOutput("tmo_race_cnt", 64'(err_cnt), 64'(expErrCnt));

        // Overrun during a reply, then a stray tx_done in IDLE
        pulseRx(8'h02);
        pulseRx(8'h01);
        checkOutput("ovr_txwr0", 64'(tx_wr), 64'd1);
        checkOutput("ovr_msb", 64'(tx_data), 64'h34);
        @(negedge clk);
        pulseRx(8'h55);
        bumpErr();
        checkOutput("ovr_err", 64'(err), 64'd1);
        checkOutput("ovr_hold", 64'(tx_wr), 64'd0);
        pulseTx();
        checkOutput("ovr_txwr1", 64'(tx_wr), 64'd1);
        checkOutput("ovr_lsb", 64'(tx_data), 64'h56);
        @(negedge clk);
        pulseTx();
        pulseTx();
        checkOutput("stray_txdone", 64'(tx_wr), 64'd0);
        checkOutput("ovr_cnt", 64'(err_cnt), 64'(expErrCnt));

        // Reset between data bytes of a write
        pulseRx(8'h01);
        pulseRx(8'h02);
        pulseRx(8'hAA);
        #2 rst_n = 1'b1;
        #1;
        checkOutput("mrst_regs", regs_o, 64'h0);
        checkOutput("mrst_txdata", 64'(tx_data), 64'h00);
        checkOutput("mrst_errcnt", 64'(err_cnt), 64'd0);
        expErrCnt = 0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        pulseRx(8'h01);
        pulseRx(8'h02);
        pulseRx(8'hBB);
        pulseRx(8'hCC);
        checkOutput("mrst_write", regs_o, 64'h0000_BBCC_0000_0000);
        checkOutput("mrst_err", 64'(err_cnt), 64'd0);

        // Reset mid-response must not produce further tx_wr
        pulseRx(8'h02);
        pulseRx(8'h02);
        checkOutput("rrst_msb", 64'(tx_data), 64'hBB);
        #2 rst_n = 1'b1;
        #1;
        checkOutput("rrst_txwr", 64'(tx_wr), 64'd0);
        @(negedge clk);
        rst_n = 1'b0;
        txSeen = 0;
        for (int i = 0; i < 10; i++) begin
            if (tx_wr) txSeen++;
            if (i % 3 == 0) pulseTx();
            else @(negedge clk);
        end
        checkOutput("rrst_no_txwr", 64'(txSeen), 64'd0);

        // Saturation of the error counter
        for (int i = 0; i < 300; i++) begin
            pulseRx(8'h10 + 8'(i % 200));
            bumpErr();
            if (i == 253) checkOutput("sat_254", 64'(err_cnt), 64'(expErrCnt));
        end
        checkOutput("sat_255", 64'(err_cnt), 64'd255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
